// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage : serial_add_pkg

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle for serial_add_ctrl; the sub line exists only under SERIAL_SUB_EN.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start,
        output a,
        output b,
        output cin,
`ifdef SERIAL_SUB_EN
        output sub,
`endif
        input  busy,
        input  done,
        input  sum,
        input  cout
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        input  cin,
`ifdef SERIAL_SUB_EN
        input  sub,
`endif
        output busy,
        output done,
        output sum,
        output cout
    );

endinterface : serial_add_ctrl_if

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single-bit full adder; the only arithmetic element of the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ c;
    assign cout = (a & b) | (c & (a ^ b));

endmodule : fa_cell

// File: rtl/serial_add_ctrl.sv
// Bit-serial {cout,sum} = a + b + cin, one bit per clock, LSB first.
// Optional macro SERIAL_SUB_EN adds a sub request that turns the operation into a - b.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH   // legal range 1..64
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_ctrl_if.slave   bus
);

    localparam int unsigned          IDX_W    = $clog2(WIDTH + 1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               cin_q, cin_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   sel_c;
    logic               a_bit_c;
    logic               b_bit_c;
    logic               fa_sum_c;
    logic               fa_cout_c;
    logic [WIDTH-1:0]   sr_shift_c;

    // Pick operand bit idx with a one-hot mask so every operand bit is consumed.
    assign sel_c   = WIDTH'(1) << idx_q;
    assign a_bit_c = |(a_q & sel_c);
    assign b_bit_c = |(b_q & sel_c);

    fa_cell u_fa (
        .a    (a_bit_c),
        .b    (b_bit_c),
        .c    (carry_q),
        .sum  (fa_sum_c),
        .cout (fa_cout_c)
    );

    // New result bit enters at the MSB; after WIDTH shifts bit 0 holds the first cell output.
    assign sr_shift_c = (sr_q >> 1) | (WIDTH'(fa_sum_c) << (WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sr_d    = sr_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                    a_d     = bus.a;
`ifdef SERIAL_SUB_EN
                    // Two's-complement subtract: invert b and force the initial carry.
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    cin_d   = bus.sub | bus.cin;
`else
                    b_d     = bus.b;
                    cin_d   = bus.cin;
`endif
                end
            end
            LOAD: begin
                state_d = RUN;
                idx_d   = '0;
                carry_d = cin_q;
            end
            RUN: begin
                sr_d    = sr_shift_c;
                carry_d = fa_cout_c;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                    sum_d   = sr_shift_c;
                    cout_d  = fa_cout_c;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == LOAD) || (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sr_q    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sr_q    <= sr_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule : serial_add_ctrl
